// File: rtl/cas_pkg.sv
// Shared helpers for the bitonic compare-and-swap sorting network:
// stage-count arithmetic, the IEEE-754 ordering key map and the record layout width.
package cas_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int num_stages(input int n);
    int l;
    l = clog2(n);
    return l * (l + 1) / 2;
  endfunction

  // Record is packed as {valid, index, value}, valid in the MSB.
  function automatic int rec_width(input int addrw, input int wl);
    return 1 + addrw + wl;
  endfunction

  // Maps a w-bit IEEE-754 pattern onto an unsigned key with the same order
  // (negatives inverted, non-negatives get the sign bit set); upper bits are zero.
  function automatic logic [63:0] float_key(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    logic [63:0] sbit;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sbit = 64'd1 << (w - 1);
    if ((v & sbit) != 64'd0) return ~v & mask;
    return (v ^ sbit) & mask;
  endfunction

endpackage

// File: rtl/cas_cell.sv
// Combinational compare-exchange of two {valid, index, value} records.
// CAS_TIEBREAK_INDEX_EN: equal keys of valid records are ordered by ascending index.
module cas_cell
  import cas_pkg::*;
#(
  parameter  int ADDRW     = 10,
  parameter  int WL        = 32,
  parameter  int FLOAT_KEY = 1,
  localparam int RW        = rec_width(ADDRW, WL)
) (
  input  logic [RW-1:0] a_i,
  input  logic [RW-1:0] b_i,
  input  logic          desc_i,
  input  logic          rev_i,
  output logic [RW-1:0] lo_o,
  output logic [RW-1:0] hi_o
);

  typedef struct packed {
    logic             valid;
    logic [ADDRW-1:0] index;
    logic [WL-1:0]    value;
  } rec_t;

  rec_t a;
  rec_t b;
  logic swap;

  assign a = a_i;
  assign b = b_i;

  // Strict "x precedes y": valid first, then key in frame direction, then tie rule.
  function automatic logic precedes(input rec_t x, input rec_t y, input logic desc);
    logic [63:0] kx;
    logic [63:0] ky;
    logic        r;
    kx = (FLOAT_KEY != 0) ? float_key(64'(x.value), WL) : 64'(x.value);
    ky = (FLOAT_KEY != 0) ? float_key(64'(y.value), WL) : 64'(y.value);
    r  = 1'b0;
    if (x.valid != y.valid) r = x.valid;
    else if (x.valid && (kx != ky)) r = desc ? (kx > ky) : (kx < ky);
`ifdef CAS_TIEBREAK_INDEX_EN
    else if (x.valid) r = (x.index < y.index);
`endif
    return r;
  endfunction

  // A reversed cell sorts its pair against the frame order, as bitonic merging needs.
  assign swap = rev_i ? precedes(a, b, desc_i) : precedes(b, a, desc_i);
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/cas_sort_net.sv
// Fully pipelined bitonic sorting network, one registered CAS layer per stage.
// CAS_TIEBREAK_INDEX_EN selects index-ordered ties inside every cas_cell.
module cas_sort_net
  import cas_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ADDRW     = 10,
  parameter int WL        = 32,
  parameter int FLOAT_KEY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       in_vld,
  input  logic                       in_desc,
  input  logic [NUM_LANES-1:0]       in_valid,
  input  logic [NUM_LANES*ADDRW-1:0] in_index,
  input  logic [NUM_LANES*WL-1:0]    in_value,
  output logic                       out_vld,
  output logic                       out_desc,
  output logic [NUM_LANES-1:0]       out_valid,
  output logic [NUM_LANES*ADDRW-1:0] out_index,
  output logic [NUM_LANES*WL-1:0]    out_value
);

  localparam int L = clog2(NUM_LANES);
  localparam int S = num_stages(NUM_LANES);

  typedef struct packed {
    logic             valid;
    logic [ADDRW-1:0] index;
    logic [WL-1:0]    value;
  } rec_t;

  rec_t       in_rec [NUM_LANES];
  rec_t       rec_d  [S][NUM_LANES];
  rec_t       rec_q  [S][NUM_LANES];
  logic [S-1:0] vld_q;
  logic [S-1:0] desc_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_in
    assign in_rec[i] = '{valid: in_valid[i],
                         index: in_index[i*ADDRW +: ADDRW],
                         value: in_value[i*WL +: WL]};
  end

  // Phase p merges blocks of K = 2^p lanes; step q compares lanes J apart.
  for (genvar p = 1; p <= L; p++) begin : g_phase
    for (genvar q = 0; q < p; q++) begin : g_step
      localparam int SI = p * (p - 1) / 2 + q;
      localparam int J  = 1 << (p - 1 - q);
      localparam int K  = 1 << p;

      rec_t src [NUM_LANES];
      logic src_desc;

      if (SI == 0) begin : g_first
        assign src      = in_rec;
        assign src_desc = in_desc;
      end else begin : g_next
        assign src      = rec_q[SI-1];
        assign src_desc = desc_q[SI-1];
      end

      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        if ((i & J) == 0) begin : g_cell
          cas_cell #(
            .ADDRW    (ADDRW),
            .WL       (WL),
            .FLOAT_KEY(FLOAT_KEY)
          ) u_cell (
            .a_i   (src[i]),
            .b_i   (src[i+J]),
            .desc_i(src_desc),
            .rev_i ((i & K) != 0),
            .lo_o  (rec_d[SI][i]),
            .hi_o  (rec_d[SI][i+J])
          );
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      desc_q <= '0;
      for (int s = 0; s < S; s++) begin
        for (int i = 0; i < NUM_LANES; i++) rec_q[s][i] <= '0;
      end
    end else if (ena) begin
      vld_q[0]  <= in_vld;
      desc_q[0] <= in_desc;
      for (int s = 1; s < S; s++) begin
        vld_q[s]  <= vld_q[s-1];
        desc_q[s] <= desc_q[s-1];
      end
      for (int s = 0; s < S; s++) begin
        for (int i = 0; i < NUM_LANES; i++) rec_q[s][i] <= rec_d[s][i];
      end
    end
  end

  assign out_vld  = vld_q[S-1];
  assign out_desc = desc_q[S-1];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_out
    assign out_valid[i]                 = rec_q[S-1][i].valid;
    assign out_index[i*ADDRW +: ADDRW]  = rec_q[S-1][i].index;
    assign out_value[i*WL +: WL]        = rec_q[S-1][i].value;
  end

endmodule

// File: tb/tb_cas_sort_net.sv
// Directed bench for cas_sort_net: N=4 float sort with latency, stall and reset
// scoreboarding, plus an N=2 instance for signed-zero ordering.
module tb_cas_sort_net;

  localparam int S  = 3;
  localparam int EW = 1 + 4 + 40 + 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         in_vld;
  logic         in_desc;
  logic [3:0]   in_valid;
  logic [39:0]  in_index;
  logic [127:0] in_value;
  logic         out_vld;
  logic         out_desc;
  logic [3:0]   out_valid;
  logic [39:0]  out_index;
  logic [127:0] out_value;

  logic         b_ena;
  logic         b_in_vld;
  logic         b_in_desc;
  logic [1:0]   b_in_valid;
  logic [19:0]  b_in_index;
  logic [63:0]  b_in_value;
  logic         b_out_vld;
  logic         b_out_desc;
  logic [1:0]   b_out_valid;
  logic [19:0]  b_out_index;
  logic [63:0]  b_out_value;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cyc   = 0;
  logic adv      = 1'b0;
  logic mon_on   = 1'b0;
  logic hold_vld = 1'b0;
  logic [EW-1:0] last_exp = '0;
  logic [EW-1:0] exp_q[$];
  int            exp_t_q[$];
  logic [39:0]   tie_idx;

  cas_sort_net #(.NUM_LANES(4), .ADDRW(10), .WL(32), .FLOAT_KEY(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in_vld   (in_vld),
    .in_desc  (in_desc),
    .in_valid (in_valid),
    .in_index (in_index),
    .in_value (in_value),
    .out_vld  (out_vld),
    .out_desc (out_desc),
    .out_valid(out_valid),
    .out_index(out_index),
    .out_value(out_value)
  );

  cas_sort_net #(.NUM_LANES(2), .ADDRW(10), .WL(32), .FLOAT_KEY(1)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .ena      (b_ena),
    .in_vld   (b_in_vld),
    .in_desc  (b_in_desc),
    .in_valid (b_in_valid),
    .in_index (b_in_index),
    .in_value (b_in_value),
    .out_vld  (b_out_vld),
    .out_desc (b_out_desc),
    .out_valid(b_out_valid),
    .out_index(b_out_index),
    .out_value(b_out_value)
  );

  // clock / enabled-cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    adv = ena && !rst;
    if (adv) en_cyc++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [EW-1:0] e);
    logic [3:0]   e_valid;
    logic [39:0]  imask;
    logic [127:0] vmask;
    e_valid = e[171:168];
    imask   = '0;
    vmask   = '0;
    for (int l = 0; l < 4; l++) begin
      if (e_valid[l]) begin
        imask[l*10 +: 10] = '1;
        vmask[l*32 +: 32] = '1;
      end
    end
    check({tag, "_vld"},   out_vld, 1'b1);
    check({tag, "_desc"},  out_desc, e[172]);
    check({tag, "_valid"}, out_valid, e_valid);
    check({tag, "_index"}, out_index & imask, e[167:128] & imask);
    check({tag, "_value"}, out_value & vmask, e[127:0] & vmask);
  endtask

  // scoreboard: a frame is due exactly S enabled cycles after it was accepted
  always @(negedge clk) begin
    if (mon_on) begin
      if (adv) begin
        if (exp_q.size() > 0 && exp_t_q[0] == en_cyc) begin
          last_exp = exp_q.pop_front();
          void'(exp_t_q.pop_front());
          hold_vld = 1'b1;
          check_frame("out", last_exp);
        end else begin
          hold_vld = 1'b0;
          check("idle_vld", out_vld, 1'b0);
        end
      end else if (hold_vld) begin
        check_frame("hold", last_exp);
      end
    end
  end

  // driver tasks
  task automatic send(input logic desc, input logic [3:0] valid, input logic [39:0] idx,
                      input logic [127:0] val, input logic [3:0] e_valid,
                      input logic [39:0] e_idx, input logic [127:0] e_val);
    ena      = 1'b1;
    in_vld   = 1'b1;
    in_desc  = desc;
    in_valid = valid;
    in_index = idx;
    in_value = val;
    exp_q.push_back({desc, e_valid, e_idx, e_val});
    exp_t_q.push_back(en_cyc + S);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ena    = 1'b1;
    in_vld = 1'b0;
    in_valid = 4'($urandom_range(0, 15));
    repeat (n) @(negedge clk);
  endtask

  task automatic stall(input int n);
    ena    = 1'b0;
    in_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // frames: lane 0 in the LSBs
  localparam logic [127:0] V_MIX   = {32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h40000000};
  localparam logic [39:0]  I_0123  = {10'd3, 10'd2, 10'd1, 10'd0};
  localparam logic [127:0] V_ASC   = {32'h40000000, 32'h3F800000, 32'h3F000000, 32'hBF800000};
  localparam logic [39:0]  I_ASC   = {10'd0, 10'd3, 10'd2, 10'd1};
  localparam logic [127:0] V_DSC   = {32'hBF800000, 32'h3F000000, 32'h3F800000, 32'h40000000};
  localparam logic [39:0]  I_DSC   = {10'd1, 10'd2, 10'd3, 10'd0};
  localparam logic [127:0] V_PART  = {32'h41100000, 32'h3F000000, 32'h41100000, 32'h3F800000};
  localparam logic [127:0] V_PARTS = {32'h0, 32'h0, 32'h3F800000, 32'h3F000000};
  localparam logic [39:0]  I_PARTS = {10'd0, 10'd0, 10'd0, 10'd2};
  localparam logic [127:0] V_TIE   = {4{32'h3F800000}};
  localparam logic [39:0]  I_TIE   = {10'd0, 10'd2, 10'd1, 10'd3};
  localparam logic [127:0] V_NEG   = {32'hBF800000, 32'h00000000, 32'h80000000, 32'hC0000000};
  localparam logic [127:0] V_NEGS  = {32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0000000};
  localparam logic [39:0]  I_NEGS  = {10'd2, 10'd1, 10'd3, 10'd0};
  localparam logic [127:0] V_PD    = {32'h40E00000, 32'h40400000, 32'h3F800000, 32'h40A00000};
  localparam logic [127:0] V_PDS   = {32'h0, 32'h0, 32'h3F800000, 32'h40400000};
  localparam logic [39:0]  I_PDS   = {10'd0, 10'd0, 10'd1, 10'd2};

  initial begin
`ifdef CAS_TIEBREAK_INDEX_EN
    tie_idx = {10'd3, 10'd2, 10'd1, 10'd0};
`else
    tie_idx = I_TIE;
`endif
    rst        = 1'b1;
    ena        = 1'b0;
    in_vld     = 1'b0;
    in_desc    = 1'b0;
    in_valid   = '0;
    in_index   = '0;
    in_value   = '0;
    b_ena      = 1'b1;
    b_in_vld   = 1'b0;
    b_in_desc  = 1'b0;
    b_in_valid = '0;
    b_in_index = '0;
    b_in_value = '0;

    #12;
    check("reset_vld",   out_vld, 1'b0);
    check("reset_desc",  out_desc, 1'b0);
    check("reset_valid", out_valid, 4'b0);
    check("reset_index", out_index, 40'b0);
    check("reset_value", out_value, 128'b0);
    check("reset_b_vld", b_out_vld, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;
    #1 mon_on = 1'b1;
    @(negedge clk);

    // directed sorts, back to back, mixed directions
    send(1'b0, 4'b1111, I_0123, V_MIX,   4'b1111, I_ASC,   V_ASC);
    send(1'b1, 4'b1111, I_0123, V_MIX,   4'b1111, I_DSC,   V_DSC);
    send(1'b0, 4'b0101, I_0123, V_PART,  4'b0011, I_PARTS, V_PARTS);
    send(1'b1, 4'b1111, I_TIE,  V_TIE,   4'b1111, tie_idx, V_TIE);
    send(1'b0, 4'b1111, I_0123, V_NEG,   4'b1111, I_NEGS,  V_NEGS);
    send(1'b1, 4'b0110, I_0123, V_PD,    4'b0011, I_PDS,   V_PDS);
    idle(5);

    // stall with a frame on the outputs, then reset with frames in flight
    send(1'b0, 4'b1111, I_0123, V_MIX,   4'b1111, I_ASC,   V_ASC);
    send(1'b1, 4'b1111, I_0123, V_MIX,   4'b1111, I_DSC,   V_DSC);
    send(1'b0, 4'b1111, I_0123, V_NEG,   4'b1111, I_NEGS,  V_NEGS);
    stall(2);
    send(1'b0, 4'b0101, I_0123, V_PART,  4'b0011, I_PARTS, V_PARTS);
    send(1'b1, 4'b1111, I_TIE,  V_TIE,   4'b1111, tie_idx, V_TIE);
    #2;
    mon_on = 1'b0;
    rst    = 1'b1;
    #1;
    check("midrst_vld",   out_vld, 1'b0);
    check("midrst_desc",  out_desc, 1'b0);
    check("midrst_valid", out_valid, 4'b0);
    check("midrst_index", out_index, 40'b0);
    check("midrst_value", out_value, 128'b0);
    exp_q.delete();
    exp_t_q.delete();
    hold_vld = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    ena    = 1'b1;
    in_vld = 1'b0;
    #1 mon_on = 1'b1;
    @(negedge clk);
    idle(2);
    send(1'b1, 4'b0110, I_0123, V_PD,    4'b0011, I_PDS,   V_PDS);
    idle(5);

    // N=2: -0.0 orders below +0.0, latency 1
    b_in_vld   = 1'b1;
    b_in_desc  = 1'b0;
    b_in_valid = 2'b11;
    b_in_index = {10'd1, 10'd0};
    b_in_value = {32'h80000000, 32'h00000000};
    #1;
    check("n2_pre_vld", b_out_vld, 1'b0);
    @(posedge clk);
    #1;
    b_in_vld = 1'b0;
    check("n2_vld",   b_out_vld, 1'b1);
    check("n2_desc",  b_out_desc, 1'b0);
    check("n2_valid", b_out_valid, 2'b11);
    check("n2_value", b_out_value, {32'h00000000, 32'h80000000});
    check("n2_index", b_out_index, {10'd0, 10'd1});
    @(posedge clk);
    #1;
    check("n2_drain_vld", b_out_vld, 1'b0);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
